// File: rtl/display_pkg.sv
// Shared constants and helpers for the display colour pipeline.
// Holds channel count, brightness width/reset value and the gamma curve.
package display_pkg;

  localparam int CHANNELS = 3;
  localparam int BRIGHT_W = 8;
  localparam logic [BRIGHT_W-1:0] BRIGHT_RST = 8'hFF;

  // Quadratic gamma curve: 0 -> 0, max in -> max out, monotonic.
  function automatic int unsigned gamma_entry(
    input int unsigned v,
    input int unsigned bw,
    input int unsigned cw
  );
    longint unsigned vv, mi, mo;
    vv = longint'(v);
    mi = (64'd1 << bw) - 64'd1;
    mo = (64'd1 << cw) - 64'd1;
    return 32'((vv * vv * mo) / (mi * mi));
  endfunction

endpackage

// File: rtl/display_color_pipeline_if.sv
// Pixel stream in / encoded stream out handshake bundle.
// master drives pixels and consumes cpixel; slave is the pipeline.
interface display_color_pipeline_if #(
  parameter int SEGMENTS   = 2,
  parameter int BITWIDTH   = 8,
  parameter int CYCLEWIDTH = 8,
  parameter int CHANNELS   = 3
);

  localparam int IW = SEGMENTS * CHANNELS * BITWIDTH;
  localparam int OW = SEGMENTS * CHANNELS * CYCLEWIDTH;

  logic [IW-1:0] pixel;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [OW-1:0] cpixel;
  logic          cpixel_valid;
  logic          cpixel_ready;

  modport master (
    output pixel,
    output pixel_valid,
    input  pixel_ready,
    input  cpixel,
    input  cpixel_valid,
    output cpixel_ready
  );

  modport slave (
    input  pixel,
    input  pixel_valid,
    output pixel_ready,
    output cpixel,
    output cpixel_valid,
    input  cpixel_ready
  );

endinterface

// File: rtl/display_gamma_lut.sv
// Single-port gamma ROM with registered output and stall enable.
// The output register doubles as the S1 data register of the pipeline.
module display_gamma_lut
  import display_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int CYCLEWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BITWIDTH-1:0]   addr,
  output logic [CYCLEWIDTH-1:0] q
);

  localparam int DEPTH = 1 << BITWIDTH;

  logic [CYCLEWIDTH-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = CYCLEWIDTH'(gamma_entry(i, BITWIDTH, CYCLEWIDTH));
  end

  // Registered read, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en) q <= rom[addr];
  end

endmodule

// File: rtl/display_color_pipeline.sv
// Three-stage colour pipeline: channel map, brightness scale, output reg.
// Define DISPLAY_COLOR_GAMMA_EN to replace the linear map with a gamma LUT.
module display_color_pipeline
  import display_pkg::*;
#(
  parameter int SEGMENTS   = 2,
  parameter int BITWIDTH   = 8,
  parameter int CYCLEWIDTH = 8,
  parameter int CHANNELS   = display_pkg::CHANNELS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                brightness_load,
  display_color_pipeline_if.slave bus
);

  localparam int N  = SEGMENTS * CHANNELS;
  localparam int PW = CYCLEWIDTH + 9;

  logic                               adv;
  logic [BRIGHT_W-1:0]                bri_q;
  logic                               v1, v2, v3;
  logic [BRIGHT_W-1:0]                b1;
  logic [N-1:0][CYCLEWIDTH-1:0]       d1, d2, d3;
  logic [N-1:0][CYCLEWIDTH-1:0]       sc;
  logic [N-1:0][PW-1:0]               prod;

  assign adv             = !v3 || bus.cpixel_ready;
  assign bus.pixel_ready = adv;
  assign bus.cpixel_valid = v3;
  assign bus.cpixel       = d3;

  // Brightness register; loads are taken even while stalled.
  always_ff @(posedge clk) begin
    if (rst)                  bri_q <= BRIGHT_RST;
    else if (brightness_load) bri_q <= brightness;
  end

  // S1 control: valid and the brightness that travels with the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      b1 <= BRIGHT_RST;
    end else if (adv) begin
      v1 <= bus.pixel_valid;
      b1 <= bri_q;
    end
  end

`ifdef DISPLAY_COLOR_GAMMA_EN
  for (genvar i = 0; i < N; i++) begin : g_lut
    display_gamma_lut #(
      .BITWIDTH  (BITWIDTH),
      .CYCLEWIDTH(CYCLEWIDTH)
    ) u_lut (
      .clk (clk),
      .en  (adv),
      .addr(bus.pixel[i*BITWIDTH +: BITWIDTH]),
      .q   (d1[i])
    );
  end
`else
  logic [N-1:0][CYCLEWIDTH-1:0] lin;

  // MSB-first replication covers both truncation and widening.
  for (genvar i = 0; i < N; i++) begin : g_lin
    for (genvar k = 0; k < CYCLEWIDTH; k++) begin : g_bit
      assign lin[i][CYCLEWIDTH-1-k] =
        bus.pixel[i*BITWIDTH + BITWIDTH-1 - (k % BITWIDTH)];
    end
  end

  // S1 data: linearly mapped channels.
  always_ff @(posedge clk) begin
    if (rst)      d1 <= '0;
    else if (adv) d1 <= lin;
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_scale
    assign prod[i] = PW'(d1[i]) * PW'({1'b0, b1} + 9'd1);
    assign sc[i]   = CYCLEWIDTH'(prod[i] >> 8);
  end

  // S2: brightness-scaled channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      d2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      d2 <= sc;
    end
  end

  // S3: output register, holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      d3 <= '0;
    end else if (adv) begin
      v3 <= v2;
      d3 <= d2;
    end
  end

endmodule

// File: tb/tb_display_color_pipeline.sv
// Self-checking bench for display_color_pipeline.
// Directed steps plus random traffic against a behavioural scoreboard.
module tb_display_color_pipeline;

  localparam int SEG = 2;
  localparam int BW  = 8;
`ifdef DISPLAY_COLOR_GAMMA_EN
  localparam int CW  = 10;
`else
  localparam int CW  = 8;
`endif
  localparam int CH  = 3;
  localparam int IW  = SEG * CH * BW;
  localparam int OW  = SEG * CH * CW;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] brightness;
  logic       brightness_load;

  always #5 clk = ~clk;

  display_color_pipeline_if #(
    .SEGMENTS(SEG), .BITWIDTH(BW), .CYCLEWIDTH(CW), .CHANNELS(CH)
  ) bus ();

  display_color_pipeline #(
    .SEGMENTS(SEG), .BITWIDTH(BW), .CYCLEWIDTH(CW), .CHANNELS(CH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .brightness     (brightness),
    .brightness_load(brightness_load),
    .bus            (bus)
  );

  int          total  = 0;
  int          passed = 0;
  logic [63:0] expq[$];
  logic [7:0]  bri_m = 8'hFF;
  logic [63:0] ones_o;
  logic [63:0] got, prev;

  // Spec-level model: map each channel, then scale by (B+1)/256.
  function automatic logic [63:0] model(input logic [63:0] px,
                                        input logic [7:0] b);
    longint unsigned r, v, m, mi, mo;
    int n;
    r  = 0;
    mi = (64'd1 << BW) - 1;
    mo = (64'd1 << CW) - 1;
    for (int i = 0; i < SEG * CH; i++) begin
      v = (px >> (i * BW)) & mi;
`ifdef DISPLAY_COLOR_GAMMA_EN
      m = v * v * mo / (mi * mi);
`else
      if (CW <= BW) m = v >> (BW - CW);
      else begin
        m = 0;
        n = 0;
        while (n < CW) begin
          m = (m << BW) | v;
          n += BW;
        end
        m = m >> (n - CW);
      end
`endif
      r |= ((m * (longint'(b) + 1)) >> 8) << (i * CW);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: score handshakes at negedge, then step past posedge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      expq.delete();
      bri_m = 8'hFF;
    end else begin
      if (bus.cpixel_valid && bus.cpixel_ready) begin
        if (expq.size() == 0)
          chk("out_expected", 64'(expq.size()), 64'd1);
        else
          chk("cpixel", 64'(bus.cpixel), expq.pop_front());
      end
      if (bus.pixel_valid && bus.pixel_ready)
        expq.push_back(model(64'(bus.pixel), bri_m));
      if (brightness_load) bri_m = brightness;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, output logic [63:0] val);
    for (int i = 0; i < 10; i++) begin
      if (bus.cpixel_valid) break;
      tick();
    end
    chk({tag, "_valid"}, 64'(bus.cpixel_valid), 64'd1);
    val = 64'(bus.cpixel);
  endtask

  task automatic drain();
    bus.pixel_valid  = 1'b0;
    bus.cpixel_ready = 1'b1;
    brightness_load  = 1'b0;
    for (int i = 0; i < 20 && expq.size() != 0; i++) tick();
    chk("drained", 64'(expq.size()), 64'd0);
  endtask

  task automatic send(input logic [IW-1:0] px);
    bus.pixel       = px;
    bus.pixel_valid = 1'b1;
    tick();
    bus.pixel_valid = 1'b0;
  endtask

  initial begin
    ones_o = (64'd1 << OW) - 1;
    rst              = 1'b1;
    brightness       = 8'h00;
    brightness_load  = 1'b0;
    bus.pixel        = '0;
    bus.pixel_valid  = 1'b0;
    bus.cpixel_ready = 1'b1;
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cvalid", 64'(bus.cpixel_valid), 64'd0);
    chk("rst_cpixel", 64'(bus.cpixel), 64'd0);
    chk("rst_pready", 64'(bus.pixel_ready), 64'd1);

    // Single beat latency and one-cycle valid.
    send({24'h000000, 24'hFFFFFF});
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("lat%0d", k), 64'(bus.cpixel_valid),
          64'(k == 3));
      tick();
    end
    drain();

    // Back-to-back stream.
    bus.pixel_valid = 1'b1;
    bus.pixel = {2{24'hFFFF00}}; tick();
    bus.pixel = {2{24'hFF00FF}}; tick();
    bus.pixel = {2{24'h00FFFF}}; tick();
    bus.pixel = {2{24'h000000}}; tick();
    bus.pixel_valid = 1'b0;
    tick();
    tick();
    chk("stream_back2back", 64'(bus.cpixel_valid), 64'd1);
    drain();

    // Brightness scaling and load timing.
    brightness = 8'h7F; brightness_load = 1'b1; tick();
    brightness_load = 1'b0;
    send({2{24'hFFFFFF}});
    wait_out("b7f", got);
`ifndef DISPLAY_COLOR_GAMMA_EN
    chk("b7f_value", got, 64'h7F7F7F7F7F7F);
`endif
    drain();
    brightness = 8'hFF; brightness_load = 1'b1; tick();
    brightness = 8'h00;
    bus.pixel = {2{24'hFFFFFF}}; bus.pixel_valid = 1'b1; tick();
    brightness_load = 1'b0;
    tick();
    bus.pixel_valid = 1'b0;
    wait_out("load_same", got);
    chk("load_same_value", got, ones_o);
    tick();
    chk("load_next_value", 64'(bus.cpixel), 64'd0);
    drain();
    brightness = 8'hFF; brightness_load = 1'b1; tick();
    brightness_load = 1'b0;

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      bus.pixel        = IW'({$urandom, $urandom});
      bus.pixel_valid  = ($urandom_range(0, 3) != 0);
      bus.cpixel_ready = ($urandom_range(0, 3) != 0);
      brightness       = 8'($urandom);
      brightness_load  = ($urandom_range(0, 9) == 0);
      tick();
    end
    drain();

    // Full pipeline held off for 5 cycles.
    bus.cpixel_ready = 1'b0;
    bus.pixel_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pixel = IW'({$urandom, $urandom});
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_pready", 64'(bus.pixel_ready), 64'd0);
      chk("stall_cvalid", 64'(bus.cpixel_valid), 64'd1);
      chk("stall_cpixel", 64'(bus.cpixel), expq[0]);
      bus.pixel = IW'({$urandom, $urandom});
      tick();
    end
    chk("stall_inflight", 64'(expq.size()), 64'd3);
    drain();

    // Reset with three beats in flight and a non-default brightness.
    brightness = 8'h40; brightness_load = 1'b1; tick();
    brightness_load  = 1'b0;
    bus.cpixel_ready = 1'b0;
    bus.pixel_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pixel = IW'({$urandom, $urandom});
      tick();
    end
    bus.pixel_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cvalid", 64'(bus.cpixel_valid), 64'd0);
    chk("mid_rst_cpixel", 64'(bus.cpixel), 64'd0);
    chk("mid_rst_pready", 64'(bus.pixel_ready), 64'd1);
    bus.cpixel_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("no_stale", 64'(bus.cpixel_valid), 64'd0);
      tick();
    end
    send({2{24'hFFFFFF}});
    wait_out("bri_rst", got);
    chk("bri_rst_value", got, ones_o);
    drain();
    send('0);
    wait_out("zeros", got);
    chk("zeros_value", got, 64'd0);
    drain();

`ifdef DISPLAY_COLOR_GAMMA_EN
    // Gamma sweep: endpoints and monotonicity per channel.
    prev = '0;
    for (int v = 0; v < 256; v++) begin
      send({(SEG * CH){8'(v)}});
      wait_out("sweep", got);
      if (v == 0)   chk("gamma_00", got & 64'h3FF, 64'h000);
      if (v == 255) chk("gamma_ff", got & 64'h3FF, 64'h3FF);
      chk("gamma_mono", 64'((got & 64'h3FF) >= (prev & 64'h3FF)), 64'd1);
      prev = got;
      drain();
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_color_pipeline.md
DISPLAY_COLOR_PIPELINE -- requirements
Module: display_color_pipeline

Interface
REQ-001 Parameter SEGMENTS, default 2: number of pixels (panel segments) processed in parallel per beat.
REQ-002 Parameter BITWIDTH, default 8: input bits per colour channel.
REQ-003 Parameter CYCLEWIDTH, default 8: output bits per colour channel (BCM cycle depth).
REQ-004 Parameter CHANNELS, default 3: colour channels per pixel, packed R,G,B from MSB to LSB.
REQ-005 clk  input  1: sole clock; all logic on rising edge.
REQ-006 rst  input  1: synchronous active-high reset.
REQ-007 pixel  input  SEGMENTS*CHANNELS*BITWIDTH: input beat; segment 0 occupies the LSBs.
REQ-008 pixel_valid  input  1: pixel holds a beat.
REQ-009 pixel_ready  output  1: block accepts a beat this cycle.
REQ-010 brightness  input  8: global brightness value.
REQ-011 brightness_load  input  1: capture brightness into the internal register this cycle.
REQ-012 cpixel  output  SEGMENTS*CHANNELS*CYCLEWIDTH: encoded beat, same segment and channel order as pixel.
REQ-013 cpixel_valid  output  1: cpixel holds a beat.
REQ-014 cpixel_ready  input  1: downstream consumes cpixel this cycle.

Function
REQ-015 A beat SHALL transfer in when pixel_valid && pixel_ready, and out when cpixel_valid && cpixel_ready.
REQ-016 The pipeline SHALL have three stages: S1 channel map, S2 brightness scale, S3 output register; latency SHALL be exactly 3 cycles from accept to cpixel_valid when not stalled.
REQ-017 Throughput SHALL be one beat per cycle while cpixel_ready is high.
REQ-018 The stall rule SHALL be global: stages advance iff !cpixel_valid || cpixel_ready; pixel_ready SHALL equal that term combinationally.
REQ-019 Bubbles (stage valid low) SHALL advance and collapse when the pipeline is not stalled.
REQ-020 While stalled, cpixel and cpixel_valid SHALL hold stable.
REQ-021 S1 linear map (macro off): CYCLEWIDTH<=BITWIDTH takes the channel MSBs; CYCLEWIDTH>BITWIDTH replicates the channel MSB-first to fill the width.
REQ-022 S2 SHALL compute out = (v * (B+1)) >> 8 per channel, where B is the brightness captured with the beat; B=255 is the identity, B=0 maps all nonzero v to 0 except the truncation result of (v*1)>>8.
REQ-023 No intermediate SHALL overflow; the S2 product width SHALL be CYCLEWIDTH+9.
REQ-024 Each beat SHALL carry the brightness register value present in its accept cycle; a load in cycle N affects beats accepted from cycle N+1 onward.
REQ-025 brightness_load SHALL be honoured regardless of stall state.
REQ-026 All-zero input SHALL yield all-zero output; all-ones input with B=255 SHALL yield all-ones output, in both configurations.

Reset
REQ-027 On rst: all stage valids, cpixel_valid = 0; cpixel = 0; brightness register = 8'hFF.
REQ-028 pixel_ready SHALL be 1 in the cycle after rst deasserts.
REQ-029 Reset mid-stream SHALL discard all in-flight beats with no output emitted for them.

Configuration
REQ-030 Macro DISPLAY_COLOR_GAMMA_EN defined: S1 SHALL use a registered gamma LUT of 2^BITWIDTH entries x CYCLEWIDTH bits, monotonic, with entry 0 = 0 and the maximum entry = all ones.
REQ-031 Macro undefined: S1 SHALL use the REQ-021 linear map.
REQ-032 Latency and handshake SHALL be identical in both configurations.

Structure
REQ-033 Package display_pkg SHALL hold CHANNELS, the brightness width (8) and the brightness reset value.
REQ-034 The LUT SHALL be sub-module display_gamma_lut (one read port, registered output, stall enable), instantiated once per channel per segment and only under DISPLAY_COLOR_GAMMA_EN.

Verification
Defaults, macro off unless stated.
REQ-035 Pixel {24'h000000, 24'hFFFFFF}, valid 1 cycle, cpixel_ready=1 -> cpixel = same value 3 cycles later, cpixel_valid high for exactly 1 cycle.
REQ-036 Stream: FFFF00, FF00FF, 00FFFF, 000000 on back-to-back cycles -> identical sequence on 4 consecutive output cycles.
REQ-037 Load B=8'h7F before FFFFFF -> each channel = 8'h7F; load B=8'h00 in the same cycle as an accept -> that beat unscaled, next beat's channels = 8'h00.
REQ-038 Hold cpixel_ready=0 for 5 cycles with the pipeline full -> pixel_ready=0, cpixel stable, no beat lost or duplicated after release.
REQ-039 Assert rst with 3 beats in flight -> cpixel_valid=0 and cpixel=0 next cycle, no stale output, brightness reads back as 8'hFF.
REQ-040 DISPLAY_COLOR_GAMMA_EN with BITWIDTH=8, CYCLEWIDTH=10: 00->000, FF->3FF, output monotonic over a 00..FF sweep.
